// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stimulus generator: FSM encoding,
// LFSR/MISR constants, vector widths and the next-state helpers.
package alu_pkg;

  localparam int OPERAND_W = 8;
  localparam int MODE_W    = 4;
  localparam int RESULT_W  = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Signature feedback taps: bits 15, 14, 12 and 3.
  localparam logic [15:0] MISR_TAPS = 16'hD008;

  // An all-zero seed would lock the LFSR, so it is mapped to 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h0000_0001 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [15:0] data,
                                            input logic        carry);
    return {sig[14:0], ^(sig & MISR_TAPS)} ^ data ^ {15'b0, carry};
  endfunction

endpackage

// File: rtl/alu_stim_gen_lfsr32.sv
// 32-bit Galois LFSR producing the pseudo-random operand stream.
module lfsr32
  import alu_pkg::*;
(
  input  logic        CLK_IN,
  input  logic        RST,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] q
);

  // Reset and load both restart the stream at the (non-zero) seed.
  always_ff @(posedge CLK_IN) begin
    if (RST || load) begin
      q <= seed_fix(seed);
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/alu_stim_gen.sv
// Drives pseudo-random operand vectors into an ALU under test and folds
// the returned results into a MISR signature.
module alu_stim_gen
  import alu_pkg::*;
#(
  parameter int          VEC_COUNT     = 30,
  parameter int          SETTLE_CYCLES = 5,
  parameter int          ALU_LATENCY   = 1,
  parameter logic [31:0] LFSR_SEED     = 32'h0000_0001
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  input  logic                 START,
  output logic [OPERAND_W-1:0] OPERA_A,
  output logic [OPERAND_W-1:0] OPERA_B,
  output logic [MODE_W-1:0]    MODE,
  output logic                 CIN,
  input  logic [RESULT_W-1:0]  ALU_OUT,
  input  logic                 COUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [7:0]           VEC_CNT,
  output logic [15:0]          SIGNATURE
);

  // A zero settle time still spends one cycle in SETTLE.
  localparam int         SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_EFF - 1);
  localparam logic [7:0] RUN_LAST    = 8'(VEC_COUNT - 1);
  localparam logic [7:0] VEC_TOTAL   = 8'(VEC_COUNT);

  logic [2:0]             state;
  logic [7:0]             settle_cnt;
  logic [7:0]             run_cnt;
  logic [31:0]            lfsr_q;
  logic [20:0]            vec_hold;
  logic [ALU_LATENCY-1:0] vld_p;
  logic                   start_run;
  logic                   issue;
  logic                   strobe;
  logic [7:0]             cnt_next;
  logic                   unused_lfsr;

  assign start_run   = START && ((state == ST_IDLE) || (state == ST_DONE));
  assign issue       = (state == ST_RUN);
  assign strobe      = vld_p[ALU_LATENCY-1];
  assign cnt_next    = VEC_CNT + {7'd0, strobe};
  assign BUSY        = (state == ST_SETTLE) || (state == ST_RUN) || (state == ST_DRAIN);
  assign DONE        = (state == ST_DONE);
  assign unused_lfsr = ^{lfsr_q[31:25], lfsr_q[23:20]};

  lfsr32 u_lfsr (
    .CLK_IN  (CLK_IN),
    .RST     (RST),
    .load    (start_run),
    .seed    (LFSR_SEED),
    .advance (issue),
    .q       (lfsr_q)
  );

  // Keep a copy of each issued vector so DRAIN can hold the last one.
  always_ff @(posedge CLK_IN) begin
    if (issue) begin
      vec_hold <= {lfsr_q[24], lfsr_q[19:16], lfsr_q[15:8], lfsr_q[7:0]};
    end
  end

  // Operands come live from the LFSR in RUN, from the hold copy in DRAIN.
  always_comb begin
    OPERA_A = '0;
    OPERA_B = '0;
    MODE    = '0;
    CIN     = 1'b0;
    if (state == ST_RUN) begin
      OPERA_A = lfsr_q[7:0];
      OPERA_B = lfsr_q[15:8];
      MODE    = lfsr_q[19:16];
      CIN     = lfsr_q[24];
    end else if (state == ST_DRAIN) begin
      OPERA_A = vec_hold[7:0];
      OPERA_B = vec_hold[15:8];
      MODE    = vec_hold[19:16];
      CIN     = vec_hold[20];
    end
  end

  // Sequencer, issue-valid delay line and signature capture.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      run_cnt    <= '0;
      vld_p      <= '0;
      VEC_CNT    <= '0;
      SIGNATURE  <= '0;
    end else begin
      // issue stage -> capture stage, ALU_LATENCY cycles apart
      vld_p[0] <= issue;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end

      if (strobe) begin
        SIGNATURE <= misr_next(SIGNATURE, ALU_OUT, COUT);
        VEC_CNT   <= cnt_next;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            run_cnt    <= '0;
            vld_p      <= '0;
            VEC_CNT    <= '0;
            SIGNATURE  <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state   <= ST_RUN;
            run_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_RUN: begin
          if (run_cnt == RUN_LAST) begin
            state <= ST_DRAIN;
          end else begin
            run_cnt <= run_cnt + 8'd1;
          end
        end
        ST_DRAIN: begin
          // Leave on the same edge that captures the final result.
          if (cnt_next == VEC_TOTAL) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_stim_gen.md
ALU_STIM_GEN -- requirements
Module: alu_stim_gen

Interface
REQ-001 Parameter VEC_COUNT, default 30, sets the number of vectors issued per run (1..255).
REQ-002 Parameter SETTLE_CYCLES, default 5, sets the idle cycles between START and the first vector (0..255).
REQ-003 Parameter ALU_LATENCY, default 1, sets the cycles from operand drive to a valid ALU_OUT/COUT (1..4).
REQ-004 Parameter LFSR_SEED, default 32'h0000_0001, sets the initial LFSR state.
REQ-005 CLK_IN  input  1  the single clock; all state updates on its rising edge.
REQ-006 RST  input  1  reset; synchronous, active-high.
REQ-007 START  input  1  single-cycle run request.
REQ-008 OPERA_A  output  8  operand A driven to the ALU.
REQ-009 OPERA_B  output  8  operand B driven to the ALU.
REQ-010 MODE  output  4  ALU operation select.
REQ-011 CIN  output  1  ALU carry-in.
REQ-012 ALU_OUT  input  16  ALU result under test.
REQ-013 COUT  input  1  ALU carry-out under test.
REQ-014 BUSY  output  1  high in the SETTLE, RUN and DRAIN states.
REQ-015 DONE  output  1  high in the DONE state.
REQ-016 VEC_CNT  output  8  number of results captured in the current run.
REQ-017 SIGNATURE  output  16  MISR signature of the captured results.

Function
REQ-018 The FSM SHALL have the states IDLE, SETTLE, RUN, DRAIN and DONE, all registered.
REQ-019 IDLE or DONE with START=1 SHALL go to SETTLE, reload the LFSR with the seed, and clear SIGNATURE, VEC_CNT and the settle counter.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to RUN; when SETTLE_CYCLES=0 it SHALL last 1 cycle.
REQ-021 RUN SHALL last exactly VEC_COUNT cycles and issue one vector per cycle: OPERA_A=lfsr[7:0], OPERA_B=lfsr[15:8], MODE=lfsr[19:16], CIN=lfsr[24].
REQ-022 The first vector SHALL use the seed itself, and the LFSR SHALL advance once after each issued vector.
REQ-023 The LFSR SHALL be a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1.
REQ-024 A seed of 0 SHALL be replaced by 32'h0000_0001.
REQ-025 OPERA_A, OPERA_B, MODE and CIN SHALL be 0 in IDLE, SETTLE and DONE, and SHALL hold the last vector through DRAIN.
REQ-026 An issue-valid bit SHALL be delayed by an ALU_LATENCY-deep shift register, and its output SHALL be the capture strobe.
REQ-027 On each capture strobe, SIGNATURE SHALL update to ({sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} ^ ALU_OUT ^ {15'b0, COUT}), and VEC_CNT SHALL increment.
REQ-028 DRAIN SHALL be entered after the last RUN cycle and SHALL go to DONE when VEC_CNT equals VEC_COUNT.
REQ-029 DONE SHALL hold SIGNATURE and VEC_CNT stable until a restart or reset.
REQ-030 START SHALL be ignored in SETTLE, RUN and DRAIN.
REQ-031 Total run length SHALL be max(SETTLE_CYCLES,1) + VEC_COUNT + ALU_LATENCY cycles from the START edge to DONE=1.

Reset
REQ-032 RST=1 at a clock edge SHALL, at that edge and from any state (including mid-RUN), force: state=IDLE, all outputs 0, LFSR=seed, the delay line cleared, and the counters cleared.
REQ-033 RST SHALL take priority over START in the same cycle.

Structure
REQ-034 A shared package alu_pkg SHALL hold the FSM state encoding, the LFSR polynomial constant, the MISR tap constant and the operand/mode widths.
REQ-035 The LFSR SHALL be a sub-module lfsr32 with ports CLK_IN, RST, load, seed, advance and q.

Verification
REQ-036 Reset: RST high for 3 cycles then low -> all outputs 0, state IDLE, BUSY=0, DONE=0.
REQ-037 First vector: seed 32'h1, SETTLE_CYCLES=2, START pulse -> BUSY=1 next cycle; first RUN cycle drives OPERA_A=8'h01, OPERA_B=8'h00, MODE=0, CIN=0.
REQ-038 Timing: VEC_COUNT=30, SETTLE_CYCLES=5, ALU_LATENCY=1 -> DONE=1 exactly 36 cycles after START; VEC_CNT=30.
REQ-039 Busy START: a START pulse during RUN -> no restart; vector sequence and DONE timing unchanged.
REQ-040 Mid-run reset: RST during vector 10 -> outputs 0 and IDLE at that edge; a later START reproduces the identical sequence from the seed.
REQ-041 Loopback: stub ALU with a 1-cycle register, ALU_OUT={OPERA_A,OPERA_B} and COUT=CIN -> SIGNATURE matches the bench reference model; seed 0 gives a signature identical to seed 1.
